magic_nor_seq: RTL and testbench
================================

MAGIC_NOR_SEQ -- requirements
Module: magic_nor_seq

Interface
REQ-001 SHALL have parameter NCELLS, default 128, meaning number of 1-bit logic cells.
REQ-002 SHALL have parameter PDEPTH, default 128, meaning number of program words.
REQ-003 SHALL have parameter AW, default 7, meaning cell/program address width (2**AW >= NCELLS, PDEPTH).
REQ-004 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port prog_we  in  1  program-word write strobe.
REQ-007 SHALL have port prog_addr  in  AW  program word address.
REQ-008 SHALL have port prog_data  in  2+3*AW  instruction {op[1:0], src_a, src_b, dst}.
REQ-009 SHALL have port in_valid  in  1  input vector offered.
REQ-010 SHALL have port in_ready  out  1  block accepts input vector.
REQ-011 SHALL have port x  in  7  primary inputs x0..x6 (x[0]=x0).
REQ-012 SHALL have port out_valid  out  1  result available.
REQ-013 SHALL have port out_ready  in  1  consumer accepts result.
REQ-014 SHALL have port z  out  1  function output z0.
REQ-015 SHALL have port err  out  1  evaluation faulted; valid with out_valid.
REQ-016 SHALL have port cycles  out  AW+1  RUN-state cycles of last evaluation; valid with out_valid.

Function
REQ-017 SHALL execute a stored NOR-only program, one instruction per RUN cycle, MAGIC style (one gate per step).
REQ-018 SHALL decode op: 00 NOR2 cell[dst]=~(cell[a]|cell[b]); 01 NOT cell[dst]=~cell[a]; 10 OUT z=cell[a], finish; 11 NOP.
REQ-019 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE.
REQ-020 SHALL assert in_ready only in IDLE; on in_valid&in_ready load cell[0..6]=x[0..6], pc=0, cycle count=0, err=0, go RUN.
REQ-021 SHALL in RUN fetch word pc, execute it same cycle, increment pc and cycle count.
REQ-022 SHALL on OUT register z=cell[src_a], go DONE next cycle; OUT counts as one cycle.
REQ-023 SHALL set err and go DONE (z=0) if pc reaches PDEPTH-1 and that word is not OUT.
REQ-024 SHALL suppress any write with dst<7 (input cells read-only), set err, continue execution.
REQ-025 SHALL treat src/dst >= NCELLS as fault: suppress write, set err, continue.
REQ-026 SHALL hold out_valid=1 with stable z, err, cycles in DONE until out_ready; return IDLE on that cycle.
REQ-027 SHALL honour prog_we only in IDLE; writes in RUN/DONE are ignored.
REQ-028 SHALL, if prog_we and in_valid coincide in IDLE, perform write and accept input; new word visible from next cycle.
REQ-029 SHALL read a cell written in the same RUN cycle as its new value only from the following cycle (no bypass needed; write-then-read across steps).

Reset
REQ-030 SHALL on rst enter IDLE, in_ready=1 on following cycle, out_valid=0, z=0, err=0, cycles=0, pc=0.
REQ-031 SHALL abandon any evaluation on rst mid-RUN or mid-DONE without producing a result.
REQ-032 SHALL not clear program memory or cell array on rst; program survives reset.

Structure
REQ-033 SHALL place op encoding enum, instruction struct, and field widths in shared package magic_pkg.
REQ-034 SHALL instantiate one sub-module magic_cell_array (2 async read ports, 1 sync write port, 7-bit parallel input load).

Verification
REQ-035 SHALL load rd73 bit-1 NOR program, sweep all 128 x -> z equals bit1 of popcount(x) every vector.
REQ-036 SHALL check x=7'b0000011 -> z=1; x=7'b0000001 -> z=0; x=7'h7F -> z=1; err=0, cycles = program length.
REQ-037 SHALL program word 0 = NOR dst=3 -> err=1 at out_valid, cell 3 still equals x[3].
REQ-038 SHALL program with no OUT -> out_valid with err=1, z=0, cycles=PDEPTH.
REQ-039 SHALL hold out_ready=0 for 10 cycles -> out_valid, z, err, cycles stable; in_ready=0 throughout.
REQ-040 SHALL assert rst mid-RUN then issue new vector -> only new vector's result appears, program unchanged.

Source files
------------

// File: rtl/magic_pkg.sv
// Shared opcode encoding, instruction layout and field widths for the MAGIC NOR sequencer.
package magic_pkg;

    localparam int N_INPUTS = 7;
    localparam int OP_W     = 2;
    localparam int MAGIC_AW = 7;
    localparam int INSTR_W  = OP_W + 3 * MAGIC_AW;

    typedef enum logic [1:0] {
        OP_NOR = 2'b00,
        OP_NOT = 2'b01,
        OP_OUT = 2'b10,
        OP_NOP = 2'b11
    } op_t;

    // Field order matches prog_data: {op, src_a, src_b, dst}, op in the MSBs.
    typedef struct packed {
        op_t                 op;
        logic [MAGIC_AW-1:0] src_a;
        logic [MAGIC_AW-1:0] src_b;
        logic [MAGIC_AW-1:0] dst;
    } instr_t;

endpackage

// File: rtl/magic_cell_array.sv
// 1-bit cell memory: two combinational read ports, one registered write port,
// parallel load of the primary-input cells. Not reset, so contents survive rst.
module magic_cell_array
    import magic_pkg::*;
#(
    parameter int NCELLS = 128,
    parameter int AW     = 7
) (
    input  logic                clk,
    input  logic                load,
    input  logic [N_INPUTS-1:0] load_data,
    input  logic [AW-1:0]       ra_addr,
    output logic                ra_data,
    input  logic [AW-1:0]       rb_addr,
    output logic                rb_data,
    input  logic                we,
    input  logic [AW-1:0]       waddr,
    input  logic                wdata
);

    localparam logic [AW:0] CELL_LIM = (AW+1)'(NCELLS);

    logic cells [NCELLS];
    logic ra_ok;
    logic rb_ok;
    logic wr_ok;

    assign ra_ok = ({1'b0, ra_addr} < CELL_LIM);
    assign rb_ok = ({1'b0, rb_addr} < CELL_LIM);
    assign wr_ok = ({1'b0, waddr} < CELL_LIM);

    // Out-of-range reads return 0 rather than aliasing onto a real cell.
    assign ra_data = ra_ok ? cells[ra_addr] : 1'b0;
    assign rb_data = rb_ok ? cells[rb_addr] : 1'b0;

    always_ff @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < N_INPUTS; i++) begin
                cells[i] <= load_data[i];
            end
        end else if (we && wr_ok) begin
            cells[waddr] <= wdata;
        end
    end

endmodule

// File: rtl/magic_nor_seq.sv
// Sequencer running a stored NOR-only program one gate per cycle; result held
// in DONE until out_ready, input accepted only in IDLE.
module magic_nor_seq
    import magic_pkg::*;
#(
    parameter int NCELLS = 128,
    parameter int PDEPTH = 128,
    parameter int AW     = 7
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 prog_we,
    input  logic [AW-1:0]        prog_addr,
    input  logic [OP_W+3*AW-1:0] prog_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [6:0]           x,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 z,
    output logic                 err,
    output logic [AW:0]          cycles
);

    localparam int IW = OP_W + 3 * AW;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [AW:0]   CELL_LIM = (AW+1)'(NCELLS);
    localparam logic [AW:0]   PROG_LIM = (AW+1)'(PDEPTH);
    localparam logic [AW-1:0] LAST_PC  = AW'(PDEPTH - 1);
    localparam logic [AW-1:0] FIRST_RW = AW'(N_INPUTS);
    localparam logic [AW-1:0] PC_ONE   = AW'(1);
    localparam logic [AW:0]   CYC_ONE  = (AW+1)'(1);

    logic [1:0]    state_q;
    logic [AW-1:0] pc_q;
    logic [AW:0]   cycles_q;
    logic          z_q;
    logic          err_q;

    logic [IW-1:0] pmem [PDEPTH];

    logic [IW-1:0] instr;
    op_t           op;
    logic [AW-1:0] src_a;
    logic [AW-1:0] src_b;
    logic [AW-1:0] dst;

    logic ra_data;
    logic rb_data;
    logic accept;
    logic a_bad;
    logic b_bad;
    logic d_bad;
    logic is_gate;
    logic fault;
    logic cell_we;
    logic wdata;

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign accept    = in_valid && in_ready;
    assign z         = z_q;
    assign err       = err_q;
    assign cycles    = cycles_q;

    // Program store: writable only while idle so a running program never changes under itself.
    always_ff @(posedge clk) begin
        if (prog_we && (state_q == S_IDLE) && ({1'b0, prog_addr} < PROG_LIM)) begin
            pmem[prog_addr] <= prog_data;
        end
    end

    assign instr = pmem[pc_q];
    assign op    = op_t'(instr[IW-1 -: OP_W]);
    assign src_a = instr[3*AW-1 -: AW];
    assign src_b = instr[2*AW-1 -: AW];
    assign dst   = instr[AW-1:0];

    always_comb begin
        a_bad   = ({1'b0, src_a} >= CELL_LIM);
        b_bad   = ({1'b0, src_b} >= CELL_LIM);
        d_bad   = ({1'b0, dst} >= CELL_LIM) || (dst < FIRST_RW);
        is_gate = (op == OP_NOR) || (op == OP_NOT);
        fault   = 1'b0;
        if (is_gate) begin
            fault = a_bad || d_bad || ((op == OP_NOR) && b_bad);
        end else if (op == OP_OUT) begin
            fault = a_bad;
        end
        cell_we = (state_q == S_RUN) && is_gate && !fault;
        wdata   = (op == OP_NOR) ? ~(ra_data | rb_data) : ~ra_data;
    end

    magic_cell_array #(
        .NCELLS (NCELLS),
        .AW     (AW)
    ) u_cells (
        .clk       (clk),
        .load      (accept),
        .load_data (x),
        .ra_addr   (src_a),
        .ra_data   (ra_data),
        .rb_addr   (src_b),
        .rb_data   (rb_data),
        .we        (cell_we),
        .waddr     (dst),
        .wdata     (wdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            cycles_q <= '0;
            z_q      <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        state_q  <= S_RUN;
                        pc_q     <= '0;
                        cycles_q <= '0;
                        err_q    <= 1'b0;
                    end
                end
                S_RUN: begin
                    pc_q     <= pc_q + PC_ONE;
                    cycles_q <= cycles_q + CYC_ONE;
                    if (fault) begin
                        err_q <= 1'b1;
                    end
                    // The last word still executes; running off its end without OUT is a fault.
                    if (op == OP_OUT) begin
                        z_q     <= ra_data;
                        state_q <= S_DONE;
                    end else if (pc_q == LAST_PC) begin
                        z_q     <= 1'b0;
                        err_q   <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_magic_nor_seq.sv
// Directed bench for magic_nor_seq: rd73 bit-1 program, faults, backpressure, reset.
module tb_magic_nor_seq;
    import magic_pkg::*;

    localparam int AW       = 7;
    localparam int RD73_LEN = 43;

    logic               clk = 1'b0;
    logic               rst;
    logic               prog_we;
    logic [AW-1:0]      prog_addr;
    logic [INSTR_W-1:0] prog_data;
    logic               in_valid;
    logic               in_ready;
    logic [6:0]         x;
    logic               out_valid;
    logic               out_ready;
    logic               z;
    logic               err;
    logic [AW:0]        cycles;

    int checks   = 0;
    int failures = 0;

    logic [INSTR_W-1:0] prog_q[$];
    int                 nxt;

    always #5 clk = ~clk;

    magic_nor_seq #(.NCELLS(128), .PDEPTH(128), .AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .z         (z),
        .err       (err),
        .cycles    (cycles)
    );

    function automatic logic [INSTR_W-1:0] mk(input op_t op, input int a, input int b, input int d);
        instr_t w;
        w.op    = op;
        w.src_a = 7'(a);
        w.src_b = 7'(b);
        w.dst   = 7'(d);
        return w;
    endfunction

    task automatic g_nor(input int a, input int b, output int d);
        d = nxt; nxt++;
        prog_q.push_back(mk(OP_NOR, a, b, d));
    endtask

    task automatic g_not(input int a, output int d);
        d = nxt; nxt++;
        prog_q.push_back(mk(OP_NOT, a, 0, d));
    endtask

    task automatic g_xnor(input int a, input int b, output int d);
        int t, u, v;
        g_nor(a, b, t); g_nor(a, t, u); g_nor(b, t, v); g_nor(u, v, d);
    endtask

    task automatic g_xor3(input int a, input int b, input int c, output int d);
        int p;
        g_xnor(a, b, p); g_xnor(p, c, d);
    endtask

    // maj = (a|b) & (c | a&b)
    task automatic g_maj(input int a, input int b, input int c, output int d);
        int na, nb, ab, n1, n2;
        g_not(a, na); g_not(b, nb); g_nor(na, nb, ab);
        g_nor(a, b, n1); g_nor(c, ab, n2); g_nor(n1, n2, d);
    endtask

    task automatic build_rd73();
        int c1, s1, c2, s2, c3, r;
        nxt = 7;
        prog_q.delete();
        g_maj(0, 1, 2, c1); g_xor3(0, 1, 2, s1);
        g_maj(3, 4, 5, c2); g_xor3(3, 4, 5, s2);
        g_maj(s1, s2, 6, c3);
        g_xor3(c1, c2, c3, r);
        prog_q.push_back(mk(OP_OUT, r, 0, 0));
    endtask

    task automatic write_word(input int a, input logic [INSTR_W-1:0] d);
        @(negedge clk);
        prog_we = 1'b1; prog_addr = 7'(a); prog_data = d;
        @(posedge clk); #1;
        prog_we = 1'b0;
    endtask

    task automatic load_program();
        foreach (prog_q[i]) write_word(i, prog_q[i]);
    endtask

    task automatic run_vector(input logic [6:0] v, input bit ack,
                              output logic zo, output logic eo, output logic [AW:0] co);
        bit got = 0;
        @(negedge clk);
        in_valid = 1'b1; x = v;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin got = 1; break; end
        end
        checks++;
        if (!got) begin failures++; $display("FAIL timeout x=%h out_valid never rose", v); end
        zo = z; eo = err; co = cycles;
        if (ack && got) begin
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (z !== 1'b0) begin failures++; $display("FAIL reset_z got=%b exp=0", z); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
        checks++; if (cycles !== 8'd0) begin failures++; $display("FAIL reset_cycles got=%0d exp=0", cycles); end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [6:0] vec [3] = '{7'b0000011, 7'b0000001, 7'h7F};
        logic       ez  [3] = '{1'b1, 1'b0, 1'b1};
        logic zo, eo;
        logic [AW:0] co;
        for (int i = 0; i < 3; i++) begin
            run_vector(vec[i], 1, zo, eo, co);
            checks++; if (zo !== ez[i]) begin failures++; $display("FAIL directed_z x=%b got=%b exp=%b", vec[i], zo, ez[i]); end
            checks++; if (eo !== 1'b0) begin failures++; $display("FAIL directed_err x=%b got=%b exp=0", vec[i], eo); end
            checks++; if (co !== 8'(RD73_LEN)) begin failures++; $display("FAIL directed_cycles x=%b got=%0d exp=%0d", vec[i], co, RD73_LEN); end
        end
    endtask

    task automatic test_sweep();
        logic zo, eo;
        logic [AW:0] co;
        int pop;
        for (int v = 0; v < 128; v++) begin
            pop = $countones(7'(v));
            run_vector(7'(v), 1, zo, eo, co);
            checks++; if (zo !== pop[1]) begin failures++; $display("FAIL sweep_z x=%h got=%b exp=%b", v, zo, pop[1]); end
        end
    endtask

    task automatic test_hold();
        logic zo, eo;
        logic [AW:0] co;
        run_vector(7'h7F, 0, zo, eo, co);
        repeat (10) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || z !== 1'b1 || err !== 1'b0 || cycles !== 8'(RD73_LEN) || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL hold got vld=%b z=%b err=%b cyc=%0d rdy=%b exp vld=1 z=1 err=0 cyc=%0d rdy=0",
                         out_valid, z, err, cycles, in_ready, RD73_LEN);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL hold_release got vld=%b rdy=%b exp vld=0 rdy=1", out_valid, in_ready); end
    endtask

    task automatic test_write_in_run();
        logic zo, eo;
        logic [AW:0] co;
        fork
            run_vector(7'h7F, 1, zo, eo, co);
            begin
                repeat (3) @(posedge clk);
                #1 prog_we = 1'b1; prog_addr = '0; prog_data = mk(OP_OUT, 3, 0, 0);
                repeat (10) @(posedge clk);
                #1 prog_we = 1'b0;
            end
        join
        checks++; if (zo !== 1'b1 || co !== 8'(RD73_LEN)) begin failures++; $display("FAIL run_write_first got z=%b cyc=%0d exp z=1 cyc=%0d", zo, co, RD73_LEN); end
        run_vector(7'h03, 1, zo, eo, co);
        checks++; if (zo !== 1'b1 || co !== 8'(RD73_LEN)) begin failures++; $display("FAIL run_write_ignored got z=%b cyc=%0d exp z=1 cyc=%0d", zo, co, RD73_LEN); end
    endtask

    task automatic test_rst_mid_run();
        logic zo, eo;
        logic [AW:0] co;
        @(negedge clk);
        in_valid = 1'b1; x = 7'h03;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || z !== 1'b0 || err !== 1'b0 || cycles !== 8'd0) begin
            failures++;
            $display("FAIL rst_mid_run_state got vld=%b rdy=%b z=%b err=%b cyc=%0d exp 0 1 0 0 0", out_valid, in_ready, z, err, cycles);
        end
        run_vector(7'h01, 1, zo, eo, co);
        checks++; if (zo !== 1'b0) begin failures++; $display("FAIL rst_mid_run_z got=%b exp=0", zo); end
        checks++; if (co !== 8'(RD73_LEN)) begin failures++; $display("FAIL rst_mid_run_cycles got=%0d exp=%0d", co, RD73_LEN); end
    endtask

    task automatic test_input_protect();
        logic zo, eo;
        logic [AW:0] co;
        write_word(0, mk(OP_NOR, 0, 1, 3));
        write_word(1, mk(OP_OUT, 3, 0, 0));
        run_vector(7'h00, 1, zo, eo, co);
        checks++; if (eo !== 1'b1) begin failures++; $display("FAIL protect_err got=%b exp=1", eo); end
        checks++; if (zo !== 1'b0) begin failures++; $display("FAIL protect_cell3 got=%b exp=0", zo); end
        checks++; if (co !== 8'd2) begin failures++; $display("FAIL protect_cycles got=%0d exp=2", co); end
        write_word(0, prog_q[0]);
        write_word(1, prog_q[1]);
    endtask

    task automatic test_simul_write_accept();
        logic zo, eo;
        logic [AW:0] co;
        fork
            run_vector(7'b0100000, 1, zo, eo, co);
            begin
                @(negedge clk);
                prog_we = 1'b1; prog_addr = '0; prog_data = mk(OP_OUT, 5, 0, 0);
                @(posedge clk); #1;
                prog_we = 1'b0;
            end
        join
        checks++; if (zo !== 1'b1 || eo !== 1'b0 || co !== 8'd1) begin failures++; $display("FAIL simul_write got z=%b err=%b cyc=%0d exp z=1 err=0 cyc=1", zo, eo, co); end
        write_word(0, prog_q[0]);
    endtask

    task automatic test_no_out();
        logic zo, eo;
        logic [AW:0] co;
        for (int i = 0; i < 128; i++) write_word(i, mk(OP_NOP, 0, 0, 0));
        run_vector(7'h7F, 1, zo, eo, co);
        checks++; if (eo !== 1'b1) begin failures++; $display("FAIL no_out_err got=%b exp=1", eo); end
        checks++; if (zo !== 1'b0) begin failures++; $display("FAIL no_out_z got=%b exp=0", zo); end
        checks++; if (co !== 8'd128) begin failures++; $display("FAIL no_out_cycles got=%0d exp=128", co); end
    endtask

    initial begin
        rst = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
        in_valid = 1'b0; x = '0; out_ready = 1'b0;
        test_reset();
        build_rd73();
        load_program();
        test_directed();
        test_sweep();
        test_hold();
        test_write_in_run();
        test_rst_mid_run();
        test_input_protect();
        test_simul_write_accept();
        test_no_out();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
